// File: rtl/paralelo_serie_tx.sv
// Serial PHY transmitter: byte FIFO on a valid/ready interface, serialised MSB-first.
// After reset a COMMA preamble aligns the far-end receiver; COMMA idles fill empty slots.
module paralelo_serie_tx #(
   parameter int          FIFO_DEPTH  = 4,
   parameter int          BC_PREAMBLE = 4,
   parameter logic [7:0]  COMMA       = 8'hBC
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       byte_start,
   output logic       tx_active
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [4:0]       PRE_LEN  = 5'(BC_PREAMBLE);

   typedef enum logic {
      SYNC   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t           state_reg, state_next;

   logic [2:0]       bit_cnt_reg, bit_cnt_next;
   logic [7:0]       cur_byte_reg, cur_byte_next;
   logic [3:0]       sync_cnt_reg, sync_cnt_next;
   logic             data_out_reg, data_out_next;
   logic             byte_start_reg, byte_start_next;
   logic             tx_active_reg, tx_active_next;

   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [7:0]       fifo_head;

   logic             boundary;
   logic             sync_last;
   logic             data_slot;
   logic             push;
   logic             pop;

   // All next-byte decisions are taken from pre-edge state only.
   assign boundary  = (bit_cnt_reg == 3'd0);
   assign sync_last = (state_reg == SYNC) && (({1'b0, sync_cnt_reg} + 5'd1) >= PRE_LEN);
   assign data_slot = boundary && ((state_reg == ACTIVE) || sync_last);
   assign pop       = data_slot && (count_reg != '0);
   assign ready_out = (count_reg != FULL_CNT);
   assign push      = valid_in && ready_out;
   assign fifo_head = mem[rd_ptr_reg];

   assign data_out   = data_out_reg;
   assign byte_start = byte_start_reg;
   assign tx_active  = tx_active_reg;

   // State register
   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         state_reg <= SYNC;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      if ((state_reg == SYNC) && boundary && sync_last) begin
         state_next = ACTIVE;
      end
   end

   // Output and datapath next values
   always_comb begin
      data_out_next   = cur_byte_reg[bit_cnt_reg];
      byte_start_next = (bit_cnt_reg == 3'd7);
      tx_active_next  = (state_next == ACTIVE);
      bit_cnt_next    = bit_cnt_reg - 3'd1;
      cur_byte_next   = cur_byte_reg;
      sync_cnt_next   = sync_cnt_reg;
      if (boundary) begin
         cur_byte_next = pop ? fifo_head : COMMA;
         if (state_reg == SYNC) begin
            sync_cnt_next = sync_cnt_reg + 4'd1;
         end
      end
   end

   // FIFO pointer and occupancy bookkeeping
   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = count_reg;
      if (push) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         bit_cnt_reg    <= 3'd7;
         cur_byte_reg   <= COMMA;
         sync_cnt_reg   <= 4'd0;
         data_out_reg   <= 1'b0;
         byte_start_reg <= 1'b0;
         tx_active_reg  <= 1'b0;
         rd_ptr_reg     <= '0;
         wr_ptr_reg     <= '0;
         count_reg      <= '0;
      end else begin
         bit_cnt_reg    <= bit_cnt_next;
         cur_byte_reg   <= cur_byte_next;
         sync_cnt_reg   <= sync_cnt_next;
         data_out_reg   <= data_out_next;
         byte_start_reg <= byte_start_next;
         tx_active_reg  <= tx_active_next;
         rd_ptr_reg     <= rd_ptr_next;
         wr_ptr_reg     <= wr_ptr_next;
         count_reg      <= count_next;
      end
   end

   // Storage is not reset; occupancy alone defines which entries are live.
   always_ff @(posedge clk_8f) begin
      if (push) begin
         mem[wr_ptr_reg] <= data_in;
      end
   end

endmodule

// File: tb/tb_paralelo_serie_tx.sv
// Randomised and directed bench for paralelo_serie_tx against a slot-level queue model
// and an in-bench deserialiser that recovers non-COMMA bytes from the serial line.
module tb_paralelo_serie_tx;

   localparam int         FIFO_DEPTH  = 4;
   localparam int         BC_PREAMBLE = 4;
   localparam logic [7:0] COMMA       = 8'hBC;

   logic       clk_8f = 1'b0;
   logic       reset  = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out;
   logic       data_out;
   logic       byte_start;
   logic       tx_active;

   int n_cmp = 0;
   int n_err = 0;

   // Model: edges since reset release, bytes accepted but not yet sent, byte of current slot
   int         edges;
   logic [7:0] mq [$];
   logic [7:0] slot_byte;
   logic       last_acc;

   // Deserialised non-COMMA bytes seen on the line
   logic [7:0] rxq [$];
   logic [7:0] rx_sh;
   int         rx_cnt;

   paralelo_serie_tx #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .BC_PREAMBLE(BC_PREAMBLE),
      .COMMA      (COMMA)
   ) dut (
      .clk_8f    (clk_8f),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .byte_start(byte_start),
      .tx_active (tx_active)
   );

   always #5 clk_8f = ~clk_8f;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edges);
      end
   endtask

   // One clock edge: inputs were set before the call and stay stable across the edge.
   task automatic tick();
      int         pos;
      logic       exp_bit;
      logic       rdy_pre;
      pos      = edges % 8;
      rdy_pre  = (mq.size() < FIFO_DEPTH);
      last_acc = 1'b0;
      @(posedge clk_8f);
      #1;
      exp_bit = slot_byte[7-pos];
      if (pos == 7) begin
         if (((edges / 8) + 1) >= BC_PREAMBLE && mq.size() > 0)
            slot_byte = mq.pop_front();
         else
            slot_byte = COMMA;
      end
      if (valid_in && rdy_pre) begin
         mq.push_back(data_in);
         last_acc = 1'b1;
      end
      edges++;
      check_val("data_out",   32'(data_out),   32'(exp_bit));
      check_val("byte_start", 32'(byte_start), 32'(pos == 0));
      check_val("tx_active",  32'(tx_active),  32'(edges >= 8 * BC_PREAMBLE));
      check_val("ready_out",  32'(ready_out),  32'(mq.size() < FIFO_DEPTH));
      if (byte_start) begin
         rx_sh  = {7'b0, data_out};
         rx_cnt = 1;
      end else if (rx_cnt > 0) begin
         rx_sh  = {rx_sh[6:0], data_out};
         rx_cnt++;
      end
      if (rx_cnt == 8) begin
         if (rx_sh != COMMA) rxq.push_back(rx_sh);
         rx_cnt = 0;
      end
   endtask

   // Asserts reset between edges, checks the asynchronous clear, releases on a falling edge.
   task automatic reset_pulse(input int hold);
      #2;
      valid_in = 1'b0;
      reset    = 1'b0;
      #1;
      check_val("rst_data_out",   32'(data_out),   32'd0);
      check_val("rst_byte_start", 32'(byte_start), 32'd0);
      check_val("rst_tx_active",  32'(tx_active),  32'd0);
      check_val("rst_ready_out",  32'(ready_out),  32'd1);
      repeat (hold) @(posedge clk_8f);
      @(negedge clk_8f);
      reset     = 1'b1;
      edges     = 0;
      mq.delete();
      rxq.delete();
      slot_byte = COMMA;
      rx_cnt    = 0;
      rx_sh     = 8'h00;
   endtask

   task automatic run_idle(input int n);
      valid_in = 1'b0;
      repeat (n) tick();
   endtask

   task automatic push_one(input logic [7:0] b);
      valid_in = 1'b1;
      data_in  = b;
      tick();
      valid_in = 1'b0;
   endtask

   initial begin
      logic       saw_full;
      logic [7:0] seq;
      int         n_acc;
      edges     = 0;
      slot_byte = COMMA;
      rx_cnt    = 0;
      rx_sh     = 8'h00;

      // Preamble followed by idles
      reset_pulse(2);
      run_idle(64);
      check_val("idle_rx_count", 32'(rxq.size()), 32'd0);

      // Byte queued during SYNC waits for the end of the preamble
      reset_pulse(2);
      run_idle(3);
      push_one(8'hA5);
      run_idle(56);
      check_val("sync_rx_count", 32'(rxq.size()), 32'd1);
      if (rxq.size() > 0) check_val("sync_rx_byte", 32'(rxq[0]), 32'hA5);

      // Push exactly on a boundary edge with an empty FIFO: no bypass
      rxq.delete();
      for (int i = 0; i < 8 && (edges % 8) != 7; i++) tick();
      push_one(8'h3C);
      run_idle(24);
      check_val("nobypass_rx_count", 32'(rxq.size()), 32'd1);
      if (rxq.size() > 0) check_val("nobypass_rx_byte", 32'(rxq[0]), 32'h3C);

      // Back-pressure: continuous stream of incrementing bytes
      rxq.delete();
      saw_full = 1'b0;
      seq      = 8'h01;
      n_acc    = 0;
      valid_in = 1'b1;
      data_in  = seq;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (last_acc) begin
            n_acc++;
            seq++;
            data_in = seq;
         end
         if (!ready_out) saw_full = 1'b1;
      end
      run_idle(64);
      check_val("stream_saw_full", 32'(saw_full), 32'd1);
      check_val("stream_rx_count", 32'(rxq.size()), 32'(n_acc));
      for (int i = 0; i < rxq.size(); i++) check_val("stream_rx_byte", 32'(rxq[i]), 32'(i + 1));

      // Reset in the middle of a data byte with two bytes still queued
      reset_pulse(2);
      valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_in = 8'h11 + 8'(i);
         tick();
      end
      valid_in = 1'b0;
      for (int i = 0; i < 64 && edges < 8 * BC_PREAMBLE + 4; i++) tick();
      reset_pulse(3);
      run_idle(8 * BC_PREAMBLE + 24);
      check_val("midrst_rx_count", 32'(rxq.size()), 32'd0);

      // Loopback-style recovery of three data bytes
      rxq.delete();
      push_one(8'h00);
      push_one(8'hFF);
      push_one(8'h5A);
      run_idle(48);
      check_val("loop_rx_count", 32'(rxq.size()), 32'd3);
      if (rxq.size() == 3) begin
         check_val("loop_rx_b0", 32'(rxq[0]), 32'h00);
         check_val("loop_rx_b1", 32'(rxq[1]), 32'hFF);
         check_val("loop_rx_b2", 32'(rxq[2]), 32'h5A);
      end

      // Random traffic with varying density and occasional resets
      reset_pulse(1);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 399) == 0) reset_pulse($urandom_range(1, 3));
         valid_in = ($urandom_range(0, 7) < ((i / 250) % 4) * 2 + 1);
         data_in  = 8'($urandom);
         tick();
      end
      run_idle(64);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
